// File: rtl/rkx_ctrl.sv
// rkx_ctrl: RK8E-style disk controller -- IOT decode, status/command registers and backend transfer sequencer.
// Optional transfer watchdog is compiled in when RKX_TIMEOUT_EN is defined.
module rkx_ctrl #(
   parameter logic [5:0]  DEV_CODE       = 6'o74,
   parameter int unsigned NDRIVES        = 4,
   parameter int unsigned MAX_CYL        = 203,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [0:11] instruction,
   input  logic [4:0]  state,
   input  logic [0:11] ac,
   input  logic        UF,
   output logic [0:11] disk_bus,
   output logic        skip,
   output logic        interrupt,
   output logic        be_req,
   output logic [1:0]  be_op,
   output logic [0:14] be_disk_addr,
   output logic [0:14] be_mem_addr,
   output logic        be_len,
   output logic        be_abort,
   input  logic        be_ack,
   input  logic        be_done,
   input  logic        be_err
);

   // CPU major-state code of the IOT execute cycle
   localparam logic [4:0] F1 = 5'd1;

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} fsm_t;
   fsm_t fsm_q, fsm_d;

   logic [0:11] cmd_reg, car, dar, status;
   logic [3:0]  write_lock;
   logic        st_done, st_wlk, st_drv, st_cyl, st_tim;
   logic        set_done, set_wlk, set_drv, set_cyl;
   logic        iot_f1, dev_hit, caf, init;
   logic        do_dskp, do_dclc, do_dlag, do_dlca, do_drst, do_dldc;
   logic        busy, flag, dlag_go, abort_dclc, timeout, status_clr;
   logic        drv_bad, cyl_bad, wlk_bad;
   logic [1:0]  drive;
   logic [7:0]  cyl;
   logic [2:0]  fn;

   assign iot_f1  = (state == F1) && !UF;
   assign dev_hit = iot_f1 && (instruction[0:8] == {3'o6, DEV_CODE});
   assign caf     = iot_f1 && (instruction == 12'o6007);
   assign init    = clear || caf;
   assign fn      = instruction[9:11];

   assign do_dskp = dev_hit && (fn == 3'd1);
   assign do_dclc = dev_hit && (fn == 3'd2);
   assign do_dlag = dev_hit && (fn == 3'd3);
   assign do_dlca = dev_hit && (fn == 3'd4);
   assign do_drst = dev_hit && (fn == 3'd5);
   assign do_dldc = dev_hit && (fn == 3'd6);

   assign busy       = (fsm_q != S_IDLE);
   assign flag       = st_done | st_tim | st_wlk | st_drv | st_cyl;
   assign status_clr = do_dldc | do_dclc;
   assign abort_dclc = do_dclc && ac[11] && busy;
   // Transfer commands (read, read-all, write, write-all) all have cmd[1] clear
   assign dlag_go    = do_dlag && !busy && !cmd_reg[1];

   assign drive   = cmd_reg[9:10];
   assign cyl     = {cmd_reg[11], dar[0:6]};
   assign drv_bad = 32'(drive) >= NDRIVES;
   assign cyl_bad = 32'(cyl) > MAX_CYL;
   assign wlk_bad = cmd_reg[0] && write_lock[drive];

   assign status = {st_done, 4'b0000, busy, st_tim, st_wlk, 2'b00, st_drv, st_cyl};

   assign be_req       = (fsm_q == S_ISSUE);
   assign be_op        = {cmd_reg[2], cmd_reg[0]};
   assign be_len       = cmd_reg[5];
   assign be_disk_addr = {cmd_reg[9:10], cmd_reg[11], dar};
   assign be_mem_addr  = {cmd_reg[6:8], car};

   always_comb begin
      fsm_d    = fsm_q;
      set_done = 1'b0;
      set_wlk  = 1'b0;
      set_drv  = 1'b0;
      set_cyl  = 1'b0;
      case (fsm_q)
         S_IDLE:  if (dlag_go) fsm_d = S_CHECK;
         S_CHECK: begin
            fsm_d = S_DONE;
            if (drv_bad)      set_drv = 1'b1;
            else if (cyl_bad) set_cyl = 1'b1;
            else if (wlk_bad) set_wlk = 1'b1;
            else              fsm_d   = S_ISSUE;
         end
         S_ISSUE: if (be_ack) fsm_d = S_WAIT;
         S_WAIT: begin
            if (be_done) begin
               fsm_d   = S_DONE;
               set_drv = be_err;
            end
         end
         S_DONE: begin
            set_done = 1'b1;
            fsm_d    = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
      if (timeout) begin
         fsm_d   = S_DONE;
         set_drv = 1'b0;
      end
      // Aborts override any backend handshake seen in the same cycle
      if (abort_dclc || init) begin
         fsm_d    = S_IDLE;
         set_done = 1'b0;
         set_wlk  = 1'b0;
         set_drv  = 1'b0;
         set_cyl  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) fsm_q <= S_IDLE;
      else       fsm_q <= fsm_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_reg    <= '0;
         car        <= '0;
         dar        <= '0;
         write_lock <= '0;
         disk_bus   <= '0;
         skip       <= 1'b0;
         interrupt  <= 1'b0;
         be_abort   <= 1'b0;
         st_done    <= 1'b0;
         st_wlk     <= 1'b0;
         st_drv     <= 1'b0;
         st_cyl     <= 1'b0;
      end else if (init) begin
         cmd_reg    <= '0;
         car        <= '0;
         dar        <= '0;
         write_lock <= '0;
         disk_bus   <= '0;
         skip       <= 1'b0;
         interrupt  <= 1'b0;
         be_abort   <= busy;
         st_done    <= 1'b0;
         st_wlk     <= 1'b0;
         st_drv     <= 1'b0;
         st_cyl     <= 1'b0;
      end else begin
         be_abort  <= abort_dclc | timeout;
         skip      <= do_dskp & flag;
         interrupt <= flag & cmd_reg[3];
         st_done   <= (st_done & ~status_clr) | set_done |
                      (do_dldc && (ac[0:2] == 3'b011) && ac[4]);
         st_wlk    <= (st_wlk & ~status_clr) | set_wlk;
         st_drv    <= (st_drv & ~status_clr) | set_drv;
         st_cyl    <= (st_cyl & ~status_clr) | set_cyl;
         if (do_drst) disk_bus <= status;
         if (do_dlca) car <= ac;
         if (dlag_go) dar <= ac;
         if (do_dldc) begin
            cmd_reg <= ac;
            if (ac[0:2] == 3'b010) write_lock[ac[9:10]] <= 1'b1;
         end
      end
   end

`ifdef RKX_TIMEOUT_EN
   logic [23:0] wd_cnt;

   assign timeout = ((fsm_q == S_ISSUE) || (fsm_q == S_WAIT)) &&
                    (wd_cnt == TIMEOUT_CYCLES - 24'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt <= '0;
         st_tim <= 1'b0;
      end else if (init) begin
         wd_cnt <= '0;
         st_tim <= 1'b0;
      end else begin
         if ((fsm_d == S_ISSUE) && (fsm_q != S_ISSUE)) wd_cnt <= '0;
         else if ((fsm_q == S_ISSUE) || (fsm_q == S_WAIT)) wd_cnt <= wd_cnt + 24'd1;
         st_tim <= (st_tim & ~status_clr) | (timeout & ~abort_dclc);
      end
   end
`else
   logic wd_unused;
   assign wd_unused = ^TIMEOUT_CYCLES;
   assign timeout   = 1'b0;
   assign st_tim    = 1'b0;
`endif

endmodule
